// File: rtl/hazard_detect_if.sv
// hazard_detect_if: ID-stage operand bundle in, stall/hold/bubble control out; master drives id_* and flush, slave returns stall_count, id_hold, ex_bubble
interface hazard_detect_if #(parameter int REG_W = 3);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic             id_rs_used;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_wr_en;
  logic             flush;
  logic [1:0]       stall_count;
  logic             id_hold;
  logic             ex_bubble;
  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en, flush,
    input  stall_count, id_hold, ex_bubble
  );
  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en, flush,
    output stall_count, id_hold, ex_bubble
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: RAW hazard detector for a non-forwarding 5-stage pipe; ports clk, rst (sync active-high), hd (slave: id_* and flush in, stall_count/id_hold/ex_bubble out)
module hazard_detect #(parameter int REG_W = 3) (
  input logic            clk,
  input logic            rst,
  hazard_detect_if.slave hd
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t           state, state_n;
  logic [1:0]       rem, rem_n;
  logic             ex_v, mem_v;
  logic [REG_W-1:0] ex_rd, mem_rd;
  logic             live, hit_ex, hit_mem, issue;
  assign live    = hd.id_valid & ~hd.flush;
  assign hit_ex  = ex_v & ((hd.id_rs_used & (hd.id_rs == ex_rd)) | (hd.id_rt_used & (hd.id_rt == ex_rd)));
  assign hit_mem = mem_v & ((hd.id_rs_used & (hd.id_rs == mem_rd)) | (hd.id_rt_used & (hd.id_rt == mem_rd)));
  assign issue   = live & ~hd.ex_bubble;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 2'd0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      ex_rd  <= '0;
      mem_rd <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= issue & hd.id_wr_en;
      ex_rd  <= hd.id_rd;
    end
  end
  always_comb begin
    state_n = hd.flush ? IDLE
            : (state == HOLD) ? ((rem == 2'd1) ? IDLE : HOLD)
            : ((live & hit_ex) ? HOLD : IDLE);
    rem_n   = hd.flush ? 2'd0
            : (state == HOLD) ? rem - 2'd1
            : ((live & hit_ex) ? 2'd1 : rem);
  end
  always_comb begin
    hd.stall_count = (state == IDLE & live) ? (hit_ex ? 2'd2 : hit_mem ? 2'd1 : 2'd0) : 2'd0;
    hd.id_hold     = ~hd.flush & ((state == HOLD) | (live & (hit_ex | hit_mem)));
    hd.ex_bubble   = hd.flush | (state == HOLD) | (live & (hit_ex | hit_mem));
  end
endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed and random checks of hazard_detect against a timestamp-based pipeline model
module tb_hazard_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hazard_detect_if #(.REG_W(3)) hd();
  hazard_detect #(.REG_W(3)) dut (.clk(clk), .rst(rst), .hd(hd));
  typedef struct {int c; logic [2:0] rd;} wr_t;
  wr_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s = 0;
  int need = 0;
  bit pend = 0;
  int obs_bub = 0;
  int exp_bub = 0;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, act, exp, cyc);
    end
  endtask
  task automatic step(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                      input logic rtu, input logic [2:0] rd, input logic wr, input logic fl,
                      input int esc = -1, input int eh = -1, input int eb = -1);
    int k;
    int msc;
    int mh;
    int mb;
    hd.id_valid = v; hd.id_rs = rs; hd.id_rs_used = rsu; hd.id_rt = rt;
    hd.id_rt_used = rtu; hd.id_rd = rd; hd.id_wr_en = wr; hd.flush = fl;
    if (!pend && v && !fl) begin
      pend = 1; s = cyc; need = 0;
      foreach (q[i])
        if ((rsu && rs == q[i].rd) || (rtu && rt == q[i].rd)) begin
          if (cyc - q[i].c == 1) need = 2;
          else if (cyc - q[i].c == 2 && need == 0) need = 1;
        end
    end
    k   = cyc - s;
    msc = (pend && !fl && k == 0) ? need : 0;
    mh  = (pend && !fl && k < need) ? 1 : 0;
    mb  = (fl || mh != 0) ? 1 : 0;
    #1;
    chk("stall_count", int'(hd.stall_count), msc);
    chk("id_hold", int'(hd.id_hold), mh);
    chk("ex_bubble", int'(hd.ex_bubble), mb);
    chk("stall_not_3", int'(hd.stall_count == 2'b11), 0);
    if (esc >= 0) chk("dir_stall_count", int'(hd.stall_count), esc);
    if (eh >= 0) chk("dir_id_hold", int'(hd.id_hold), eh);
    if (eb >= 0) chk("dir_ex_bubble", int'(hd.ex_bubble), eb);
    obs_bub += int'(hd.ex_bubble);
    exp_bub += mb;
    if (fl) pend = 0;
    else if (pend && k == need) begin
      pend = 0;
      if (wr) q.push_back('{cyc, rd});
    end
    while (q.size() > 0 && cyc - q[0].c >= 2) void'(q.pop_front());
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    hd.id_valid = 0; hd.flush = 0; hd.id_wr_en = 0; hd.id_rs_used = 0; hd.id_rt_used = 0;
    hd.id_rs = 0; hd.id_rt = 0; hd.id_rd = 0;
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    q.delete();
    pend = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  logic       r_v, r_rsu, r_rtu, r_wr, r_fl;
  logic [2:0] r_rs, r_rt, r_rd;
  initial begin
    do_reset(2);
    idle(1);
    step(1, 4, 1, 5, 1, 1, 1, 0, 0, 0, 0);
    step(1, 5, 1, 6, 1, 2, 1, 0, 0, 0, 0);
    step(1, 6, 1, 4, 1, 3, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 5, 1, 0, 2, 1, 1);
    step(1, 3, 1, 0, 0, 5, 1, 0, 0, 1, 1);
    step(1, 3, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    step(1, 0, 0, 3, 1, 7, 1, 0, 1, 1, 1);
    step(1, 0, 0, 3, 1, 7, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    step(1, 3, 1, 3, 1, 1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 0, 0, 0, 0, 0);
    step(1, 3, 1, 3, 1, 1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 5, 1, 0, 2, 1, 1);
    step(1, 3, 1, 0, 0, 5, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 1, 7, 1, 2, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 5, 1, 0, 2, 1, 1);
    do_reset(1);
    step(1, 3, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 1, 1, 0, 2, 1, 1);
    step(1, 5, 1, 0, 0, 1, 1, 0, 0, 1, 1);
    step(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(2);
    for (int n = 0; n < 800; n++) begin
      if (!pend) begin
        r_v   = ($urandom % 8) != 0;
        r_rs  = 3'($urandom_range(0, 3));
        r_rt  = 3'($urandom_range(0, 3));
        r_rd  = 3'($urandom_range(0, 3));
        r_rsu = 1'($urandom % 2);
        r_rtu = 1'($urandom % 2);
        r_wr  = ($urandom % 4) != 0;
      end
      r_fl = ($urandom % 12) == 0;
      step(r_v, r_rs, r_rsu, r_rt, r_rtu, r_rd, r_wr, r_fl);
    end
    chk("bubble_total", obs_bub, exp_bub);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
